j1_wb_timer: RTL and testbench
==============================

# j1_wb_timer

Wishbone slave timer peripheral for the J1 system: the responder on the bus that `j1_core` drives as master. It provides a 16-bit prescaled down-counter with one-shot/auto-reload modes, a sticky expiry flag and a level interrupt. It answers the core's zero-wait-state accesses with registered read data one cycle after the strobe, and presents 0 when not selected so its output can be OR-merged with other slaves.

## Interface
- `base_adr`, default 16'h7000: block base word address; bits [2:0] ignored.
- `clk`  in  1: clock; all state changes on rising edge.
- `reset`  in  1: reset, asynchronous, active-high.
- `wb`  if_wb.slave  –: Wishbone bus. Fields used:
  - `adr` 16b word address in.
  - `dat_i` 16b write data in.
  - `dat_o` 16b read data out.
  - `stb`, `cyc`, `we` in.
  - `ack` out.
- `irq`  out  1: level interrupt = `flag & ctrl.irq_en`.

## Operation
- Select: `sel = wb.cyc & wb.stb & (wb.adr[15:3] == base_adr[15:3])`. Register index is `wb.adr[2:0]`.
- Registers:
  - 0 CTRL, R/W: bit0 `en`, bit1 `auto`, bit2 `irq_en`; other bits read 0.
  - 1 PRESC, R/W, 16b.
  - 2 RELOAD, R/W, 16b.
  - 3 COUNT, R/W, 16b.
  - 4 STATUS: bit0 `flag`, read; writing 1 to bit0 clears it, writing 0 has no effect.
  - 5–7: read 0; writes ignored.
- Write: on the edge where `sel & we`, the addressed register takes `dat_i`.
- Prescaler: internal 16b `pcnt`.
  - While `en` is set: `tick = (pcnt >= PRESC)`. On tick, `pcnt <= 0`; otherwise `pcnt <= pcnt + 1`.
  - While `en` is clear: `pcnt` holds 0 and no ticks occur.
- Counter, evaluated on each tick:
  - COUNT != 0: `COUNT <= COUNT - 1`.
  - COUNT == 0: `flag <= 1`.
    - `auto` set: `COUNT <= RELOAD`.
    - `auto` clear: COUNT stays 0 and `en <= 0` (one-shot).
- Period in auto mode: (RELOAD+1)·(PRESC+1) clocks. Decrement never wraps below 0.
- Simultaneous events, in priority order:
  - A bus write to COUNT beats a tick update in the same cycle, and also forces `pcnt <= 0`.
  - A bus write to CTRL beats a one-shot `en` clear. Writing `en=0` forces `pcnt <= 0`.
  - Flag set by expiry beats a W1C clear in the same cycle.
  - A PRESC write does not reset `pcnt`. If `pcnt` already ≥ the new PRESC, the next enabled cycle ticks.
- Reset mid-access: all state returns to reset values immediately; no `ack` is issued for the aborted access.

## Timing
- Reset values: `dat_o` = 0, `ack` = 0, `irq` = 0, CTRL = PRESC = RELOAD = COUNT = 0, `flag` = 0, `pcnt` = 0.
- `ack` is registered: `ack <= sel`. It asserts in the cycle after each selected strobe cycle, with no wait states. A continuous `stb` gives continuous `ack`.
- Read data is registered:
  - `dat_o <= (sel & !we) ? reg[adr] : 0`.
  - The value captured is the pre-edge register content, before any same-edge tick or write.
  - `dat_o` is valid in the cycle following the strobe and is 0 in every other cycle.
- Write latency: the register shows the new value from the edge that sampled `sel & we`. A read in the next cycle returns it.
- `irq` is combinational from flops only, so it is glitch-free. It rises in the cycle after the tick that sets `flag`, and falls in the cycle after a W1C clear or an `irq_en` clear.
- A strobe whose address is outside the block: no `ack`, `dat_o` = 0, no state change.

## Test plan
- Reset / register access:
  - After reset, read regs 0–7: all return 0 one cycle after `stb`, with `ack` high exactly that cycle.
  - Write PRESC = 16'h1234, then read back 16'h1234.
  - Write CTRL = 16'hFFFF, then read 16'h0007.
- Auto-reload period:
  - Setup: PRESC = 2, RELOAD = 3, COUNT = 3, CTRL = 16'h0007.
  - Required: `flag` sets every 12 clocks, `irq` is high the cycle after, and COUNT reloads to 3.
- One-shot:
  - Setup: PRESC = 0, COUNT = 5, CTRL = 16'h0001.
  - Required: after 6 clocks `flag` = 1, COUNT = 0, CTRL reads 0, and `irq` stays 0 because `irq_en` = 0.
- W1C and set priority:
  - Write STATUS = 1 on the same edge as an expiry tick: `flag` remains 1.
  - Write STATUS = 1 on a later non-tick cycle: `flag` reads 0 and `irq` drops the next cycle.
- Write/tick collision:
  - Setup: PRESC = 0, running.
  - Write COUNT = 16'h0100 on a tick edge: the next read returns 16'h0100, and the decrement resumes one clock later.
- Decode:
  - Strobe at `base_adr + 8` (read or write): `ack` = 0, `dat_o` = 0, and no register changes.
  - Assert `reset` mid-strobe: all outputs are 0 immediately.

Source files
------------

// File: rtl/j1_wb_timer.sv
// j1_wb_timer: Wishbone slave timer for the J1 system.
// It has a 16-bit prescaled down-counter with one-shot and auto-reload modes, a sticky
// expiry flag and a level interrupt. Accesses are zero-wait-state. Read data is
// registered, and the output is 0 when the block is not selected, so it can be
// OR-merged with the outputs of other slaves.
module j1_wb_timer #(
  parameter logic [15:0] BaseAdr = 16'h7000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic        irq_o
);

  localparam logic [2:0] IdxCtrl   = 3'd0;
  localparam logic [2:0] IdxPresc  = 3'd1;
  localparam logic [2:0] IdxReload = 3'd2;
  localparam logic [2:0] IdxCount  = 3'd3;
  localparam logic [2:0] IdxStatus = 3'd4;

  // ctrl bits: [0] en, [1] auto, [2] irq_en
  logic [2:0]  ctrl_q, ctrl_d;
  logic [15:0] presc_q, presc_d;
  logic [15:0] reload_q, reload_d;
  logic [15:0] count_q, count_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic        flag_q, flag_d;
  logic        ack_q, ack_d;
  logic [15:0] dat_q, dat_d;

  logic        sel;
  logic        wr_en;
  logic        rd_en;
  logic [2:0]  idx;
  logic [15:0] rdata;
  logic        tick;
  logic        expire;

  // Address decode, register read mux and timer event detection
  always_comb begin
    sel    = wb_cyc_i & wb_stb_i & (wb_adr_i[15:3] == BaseAdr[15:3]);
    idx    = wb_adr_i[2:0];
    wr_en  = sel & wb_we_i;
    rd_en  = sel & ~wb_we_i;
    tick   = ctrl_q[0] & (pcnt_q >= presc_q);
    expire = tick & (count_q == 16'd0);
    rdata  = 16'd0;
    case (idx)
      IdxCtrl:   rdata = {13'd0, ctrl_q};
      IdxPresc:  rdata = presc_q;
      IdxReload: rdata = reload_q;
      IdxCount:  rdata = count_q;
      IdxStatus: rdata = {15'd0, flag_q};
      default:   rdata = 16'd0;
    endcase
  end

  // Next-state: timer evolution first, then bus writes override where they collide
  always_comb begin
    ctrl_d   = ctrl_q;
    presc_d  = presc_q;
    reload_d = reload_q;
    count_d  = count_q;
    pcnt_d   = pcnt_q;
    flag_d   = flag_q;

    if (!ctrl_q[0]) begin
      pcnt_d = 16'd0;
    end else if (tick) begin
      pcnt_d = 16'd0;
    end else begin
      pcnt_d = pcnt_q + 16'd1;
    end

    if (tick) begin
      if (count_q != 16'd0) begin
        count_d = count_q - 16'd1;
      end else if (ctrl_q[1]) begin
        count_d = reload_q;
      end else begin
        ctrl_d[0] = 1'b0;  // one-shot expiry stops the timer
      end
    end

    if (wr_en) begin
      case (idx)
        IdxCtrl: begin
          ctrl_d = wb_dat_i[2:0];
          if (!wb_dat_i[0]) pcnt_d = 16'd0;
        end
        IdxPresc:  presc_d  = wb_dat_i;
        IdxReload: reload_d = wb_dat_i;
        IdxCount: begin
          count_d = wb_dat_i;
          pcnt_d  = 16'd0;
        end
        IdxStatus: begin
          if (wb_dat_i[0]) flag_d = 1'b0;
        end
        default: ;
      endcase
    end

    // Expiry wins over a same-edge W1C
    if (expire) flag_d = 1'b1;
  end

  // Bus response: ack and read data registered, both zero when not selected
  always_comb begin
    ack_d = sel;
    dat_d = rd_en ? rdata : 16'd0;
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q   <= 3'd0;
      presc_q  <= 16'd0;
      reload_q <= 16'd0;
      count_q  <= 16'd0;
      pcnt_q   <= 16'd0;
      flag_q   <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= 16'd0;
    end else begin
      ctrl_q   <= ctrl_d;
      presc_q  <= presc_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      pcnt_q   <= pcnt_d;
      flag_q   <= flag_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
    end
  end

  // Outputs come straight from flops
  always_comb begin
    wb_ack_o = ack_q;
    wb_dat_o = dat_q;
    irq_o    = flag_q & ctrl_q[2];
  end

endmodule

// File: tb/tb_j1_wb_timer.sv
// Self-checking bench for j1_wb_timer. A behavioural model tracks the timer and
// the bus responses. One compare process checks every cycle against the model,
// and directed scenarios add literal expectations that pin the model.
module tb_j1_wb_timer;

  localparam logic [15:0] Base = 16'h7000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] wb_adr = 16'd0;
  logic [15:0] wb_wdat = 16'd0;
  logic [15:0] wb_rdat;
  logic        wb_stb = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        wb_we = 1'b0;
  logic        wb_ack;
  logic        irq;

  j1_wb_timer #(.BaseAdr(Base)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .wb_adr_i(wb_adr),
    .wb_dat_i(wb_wdat),
    .wb_dat_o(wb_rdat),
    .wb_stb_i(wb_stb),
    .wb_cyc_i(wb_cyc),
    .wb_we_i (wb_we),
    .wb_ack_o(wb_ack),
    .irq_o   (irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc_n = 0;
  bit cmp_on = 1'b0;

  // Model state (plain integers)
  int m_en, m_auto, m_irqen, m_presc, m_reload, m_count, m_pcnt, m_flag;
  int m_ack, m_dat;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_auto = 0; m_irqen = 0; m_presc = 0; m_reload = 0;
    m_count = 0; m_pcnt = 0; m_flag = 0; m_ack = 0; m_dat = 0;
  endtask

  function automatic int m_read(input int idx);
    case (idx)
      0: return m_en + 2 * m_auto + 4 * m_irqen;
      1: return m_presc;
      2: return m_reload;
      3: return m_count;
      4: return m_flag;
      default: return 0;
    endcase
  endfunction

  function automatic bit expire_next();
    return (m_en != 0) && (m_pcnt >= m_presc) && (m_count == 0);
  endfunction

  // One clock of behaviour: bus response from pre-edge state, timer step, then writes
  task automatic model_edge(input bit c, input bit s, input bit w, input logic [15:0] a,
                            input logic [15:0] d);
    bit sel;
    int idx, rd;
    bit tick, expired;
    sel = c && s && (a[15:3] == Base[15:3]);
    idx = int'(a[2:0]);
    rd  = m_read(idx);
    tick    = (m_en != 0) && (m_pcnt >= m_presc);
    expired = tick && (m_count == 0);
    if (tick) begin
      m_pcnt = 0;
      if (m_count > 0) m_count = m_count - 1;
      else if (m_auto != 0) m_count = m_reload;
      else m_en = 0;
    end else if (m_en != 0) begin
      m_pcnt = m_pcnt + 1;
    end else begin
      m_pcnt = 0;
    end
    if (sel && w) begin
      case (idx)
        0: begin
          m_en = int'(d[0]); m_auto = int'(d[1]); m_irqen = int'(d[2]);
          if (!d[0]) m_pcnt = 0;
        end
        1: m_presc = int'(d);
        2: m_reload = int'(d);
        3: begin m_count = int'(d); m_pcnt = 0; end
        4: if (d[0]) m_flag = 0;
        default: ;
      endcase
    end
    if (expired) m_flag = 1;
    m_ack = sel ? 1 : 0;
    m_dat = (sel && !w) ? rd : 0;
  endtask

  // Drive one cycle; returns #1 after the active edge
  task automatic step(input bit c, input bit s, input bit w, input logic [15:0] a,
                      input logic [15:0] d);
    @(negedge clk);
    wb_cyc = c; wb_stb = s; wb_we = w; wb_adr = a; wb_wdat = d;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(c, s, w, a, d);
    #1;
    cyc_n++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
  endtask

  task automatic wr(input int idx, input logic [15:0] d);
    step(1'b1, 1'b1, 1'b1, Base + 16'(idx), d);
  endtask

  task automatic rd(input int idx, output int v);
    step(1'b1, 1'b1, 1'b0, Base + 16'(idx), 16'd0);
    v = int'(wb_rdat);
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_on && !rst) begin
      chk("ack", int'(wb_ack), m_ack);
      chk("dat_o", int'(wb_rdat), m_dat);
      chk("irq", int'(irq), (m_flag != 0 && m_irqen != 0) ? 1 : 0);
    end
  end

  initial begin
    int v, t0, t1, prev;
    logic [15:0] a, d;
    model_reset();
    idle(); idle();
    rst = 1'b0;
    cmp_on = 1'b1;

    // Reset state: all registers read 0, ack for exactly the response cycle
    for (int i = 0; i < 8; i++) begin
      rd(i, v);
      chk("rst_read", v, 0);
      chk("rst_ack", int'(wb_ack), 1);
    end
    idle();
    chk("ack_drop", int'(wb_ack), 0);

    wr(1, 16'h1234);
    rd(1, v);
    chk("presc_rb", v, 16'h1234);
    wr(0, 16'hFFFF);
    rd(0, v);
    chk("ctrl_rb", v, 16'h0007);

    // Auto-reload period
    wr(0, 16'h0000);
    wr(4, 16'h0001);
    wr(1, 16'd2);
    wr(2, 16'd3);
    wr(3, 16'd3);
    wr(0, 16'h0007);
    t0 = -1; t1 = -1; prev = int'(irq);
    for (int k = 0; k < 80 && t1 < 0; k++) begin
      idle();
      if (irq && prev == 0) begin
        if (t0 < 0) t0 = cyc_n;
        else t1 = cyc_n;
        wr(4, 16'h0001);
        rd(3, v);
        chk("reload_count", v, 3);
      end
      prev = int'(irq);
    end
    chk("auto_period", t1 - t0, 12);

    // W1C versus expiry on the same edge
    while (expire_next()) idle();
    wr(4, 16'h0001);
    rd(4, v);
    chk("w1c_clear", v, 0);
    for (int k = 0; k < 40 && !expire_next(); k++) idle();
    wr(4, 16'h0001);
    rd(4, v);
    chk("set_beats_w1c", v, 1);
    chk("irq_held", int'(irq), 1);
    while (expire_next()) idle();
    wr(4, 16'h0001);
    chk("irq_falls", int'(irq), 0);

    // One-shot
    wr(0, 16'h0000);
    wr(4, 16'h0001);
    wr(1, 16'd0);
    wr(3, 16'd5);
    wr(0, 16'h0001);
    for (int k = 0; k < 5; k++) idle();
    rd(4, v);
    chk("oneshot_early", v, 0);
    rd(4, v);
    chk("oneshot_flag", v, 1);
    rd(3, v);
    chk("oneshot_count", v, 0);
    rd(0, v);
    chk("oneshot_ctrl", v, 0);
    chk("oneshot_noirq", int'(irq), 0);

    // Write/tick collision
    wr(2, 16'hFFFF);
    wr(3, 16'h0050);
    wr(0, 16'h0003);
    idle(); idle(); idle();
    wr(3, 16'h0100);
    rd(3, v);
    chk("coll_write", v, 16'h0100);
    rd(3, v);
    chk("coll_resume", v, 16'h00FF);

    // Decode outside the block
    step(1'b1, 1'b1, 1'b0, Base + 16'd9, 16'd0);
    chk("oob_rd_ack", int'(wb_ack), 0);
    chk("oob_rd_dat", int'(wb_rdat), 0);
    step(1'b1, 1'b1, 1'b1, Base + 16'd10, 16'h1234);
    chk("oob_wr_ack", int'(wb_ack), 0);
    rd(2, v);
    chk("oob_no_write", v, 16'hFFFF);

    // Reset asserted mid-access with irq high
    wr(0, 16'h0004);
    rd(4, v);
    chk("pre_rst_flag", v, 1);
    rd(2, v);
    chk("pre_rst_ack", int'(wb_ack), 1);
    chk("pre_rst_irq", int'(irq), 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_ack_now", int'(wb_ack), 0);
    chk("rst_dat_now", int'(wb_rdat), 0);
    chk("rst_irq_now", int'(irq), 0);
    idle();
    rst = 1'b0;
    idle();
    rd(2, v);
    chk("post_rst_reload", v, 0);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 9) < 5) begin
        idle();
      end else begin
        int idx;
        idx = $urandom_range(0, 7);
        a = Base + 16'(idx);
        if ($urandom_range(0, 7) == 0) a = a + 16'(8 * $urandom_range(1, 200));
        case (idx)
          1: d = 16'($urandom_range(0, 3));
          2: d = 16'($urandom_range(0, 10));
          3: d = 16'($urandom_range(0, 20));
          default: d = 16'($urandom);
        endcase
        step(($urandom_range(0, 15) != 0), 1'b1, 1'($urandom_range(0, 1)), a, d);
      end
    end
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
